// File: rtl/object_spawner_multi.sv
// Falling-object manager for N_OBJ slots: periodic spawns at an LFSR-derived column,
// per-frame descent, retirement on hit or on leaving the visible area.
module object_spawner_multi #(
    parameter int N_OBJ        = 4,
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int OBJ_SIZE     = 32,
    parameter int SPEED        = 2,
    parameter int SPAWN_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 frame_tick,
    input  logic [31:0]          random_number,
    input  logic                 hit_valid,
    input  logic [3:0]           hit_index,
    output logic [N_OBJ-1:0]     object_active,
    output logic [N_OBJ*X_W-1:0] object_x,
    output logic [N_OBJ*Y_W-1:0] object_y,
    output logic                 spawn_dropped,
    output logic [7:0]           miss_count
);
    localparam int LIM   = SCREEN_W - OBJ_SIZE;
    localparam int Y_MAX = SCREEN_H - OBJ_SIZE;
    localparam int CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

    typedef enum logic {IDLE = 1'b0, FALLING = 1'b1} slot_state_t;

    slot_state_t      state [N_OBJ];
    logic [X_W-1:0]   pos_x [N_OBJ];
    logic [Y_W-1:0]   pos_y [N_OBJ];
    logic [Y_W:0]     y_step [N_OBJ];
    logic [CNT_W-1:0] spawn_cnt;
    logic [N_OBJ-1:0] hit_sel;
    logic [N_OBJ-1:0] off_screen;
    logic [N_OBJ-1:0] missed;
    logic             spawn_attempt;
    logic             spawn_found;
    logic [4:0]       spawn_slot;
    logic [4:0]       miss_total;
    logic [X_W-1:0]   rand_col;
    logic [X_W-1:0]   spawn_x;
    logic [31-X_W:0]  unused_rand;

    function automatic logic [7:0] sat_miss_add(input logic [7:0] cnt, input logic [4:0] add);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {4'b0, add};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign rand_col      = random_number[X_W-1:0];
    assign unused_rand   = random_number[31:X_W];
    // Fold out-of-range columns back into 0..LIM without a divider.
    assign spawn_x       = (rand_col > X_W'(LIM)) ? rand_col - X_W'(LIM + 1) : rand_col;
    assign spawn_attempt = frame_tick && (spawn_cnt == CNT_W'(SPAWN_FRAMES - 1));

    always_comb begin
        spawn_found = 1'b0;
        spawn_slot  = '0;
        miss_total  = '0;
        // Descending scan so the lowest idle index is the one left standing.
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            y_step[i]     = {1'b0, pos_y[i]} + (Y_W + 1)'(SPEED);
            hit_sel[i]    = hit_valid && (hit_index == 4'(i));
            off_screen[i] = y_step[i] > (Y_W + 1)'(Y_MAX);
            missed[i]     = frame_tick && (state[i] == FALLING) && off_screen[i] && !hit_sel[i];
            miss_total    = miss_total + 5'(missed[i]);
            if (state[i] == IDLE) begin
                spawn_found = 1'b1;
                spawn_slot  = 5'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_cnt     <= '0;
            spawn_dropped <= 1'b0;
            miss_count    <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                state[i] <= IDLE;
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
        end else if (enable) begin
            spawn_dropped <= spawn_attempt && !spawn_found;
            if (frame_tick)
                spawn_cnt <= spawn_attempt ? '0 : spawn_cnt + CNT_W'(1);
            miss_count <= sat_miss_add(miss_count, miss_total);
            for (int i = 0; i < N_OBJ; i++) begin
                if (state[i] == IDLE) begin
                    if (spawn_attempt && spawn_found && (spawn_slot == 5'(i))) begin
                        state[i] <= FALLING;
                        pos_x[i] <= spawn_x;
                        pos_y[i] <= '0;
                    end
                end else begin
                    if (hit_sel[i] || (frame_tick && off_screen[i]))
                        state[i] <= IDLE;
                    else if (frame_tick)
                        pos_y[i] <= y_step[i][Y_W-1:0];
                end
            end
        end else begin
            spawn_dropped <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            object_active[i]       = (state[i] == FALLING);
            object_x[i*X_W +: X_W] = pos_x[i];
            object_y[i*Y_W +: Y_W] = pos_y[i];
        end
    end
endmodule
